decode_scoreboard: RTL and testbench

//  Parametrised hazard scoreboard for the decode stage, replacing fixed load-use detection.

---
 rtl/decode_scoreboard_if.sv | 47 ++++
 rtl/decode_scoreboard.sv | 141 ++++++++++++++
 tb/tb_decode_scoreboard.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_scoreboard_if.sv
// ---------------------------------------------------------------------------
// decode_scoreboard_if
// Bundle between the decode stage and the hazard scoreboard.
//   Decode -> scoreboard : issue_valid, issue_we, issue_addr, issue_lat,
//                          rs_addr, rs_used, rt_addr, rt_used, kill, flush
//   Writeback -> board   : wb_valid, wb_addr
//   Scoreboard -> decode : stall (combinational), busy_mask, var_count, wb_err
// The master modport is the decode/writeback side, the slave modport is
// the scoreboard itself.
// ---------------------------------------------------------------------------
interface decode_scoreboard_if #(
    parameter int NUM_REGS  = 32,
    parameter int ADDR_W    = 5,
    parameter int LAT_W     = 3,
    parameter int VAR_CNT_W = 3
) ();
    logic                 issue_valid;
    logic                 issue_we;
    logic [ADDR_W-1:0]    issue_addr;
    logic [LAT_W-1:0]     issue_lat;
    logic [ADDR_W-1:0]    rs_addr;
    logic                 rs_used;
    logic [ADDR_W-1:0]    rt_addr;
    logic                 rt_used;
    logic                 kill;
    logic                 flush;
    logic                 wb_valid;
    logic [ADDR_W-1:0]    wb_addr;
    logic                 stall;
    logic [NUM_REGS-1:0]  busy_mask;
    logic [VAR_CNT_W-1:0] var_count;
    logic                 wb_err;

    modport master (
        output issue_valid, issue_we, issue_addr, issue_lat,
        output rs_addr, rs_used, rt_addr, rt_used,
        output kill, flush, wb_valid, wb_addr,
        input  stall, busy_mask, var_count, wb_err
    );

    modport slave (
        input  issue_valid, issue_we, issue_addr, issue_lat,
        input  rs_addr, rs_used, rt_addr, rt_used,
        input  kill, flush, wb_valid, wb_addr,
        output stall, busy_mask, var_count, wb_err
    );
endinterface

// File: rtl/decode_scoreboard.sv
// ---------------------------------------------------------------------------
// decode_scoreboard
// Register hazard scoreboard for the decode stage. Tracks in-flight writes
// from fixed-latency producers (per-register countdown) and from
// variable-latency producers (per-register pending bit, cleared by a
// writeback handshake).
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   sb   - decode_scoreboard_if.slave: issue/source/kill/flush/wb inputs,
//          stall (combinational), busy_mask/var_count/wb_err (registered)
// ---------------------------------------------------------------------------
module decode_scoreboard #(
    parameter int NUM_REGS  = 32,
    parameter int ADDR_W    = 5,
    parameter int LAT_W     = 3,
    parameter int MAX_VAR   = 4,
    parameter int VAR_CNT_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    decode_scoreboard_if.slave sb
);

    logic [NUM_REGS-1:0]  var_vec;
    logic [NUM_REGS-1:0]  busy_d;
    logic [NUM_REGS-1:0]  busy_mask_q;
    logic [VAR_CNT_W-1:0] var_count_q;
    logic [VAR_CNT_W-1:0] var_count_d;
    logic                 wb_err_q;
    logic                 wb_err_d;

    logic wb_hit;
    logic rs_pend;
    logic rt_pend;
    logic waw_var;
    logic var_full;
    logic stall;
    logic accept;
    logic accept_var;

    // A writeback that actually retires an outstanding variable op.
    assign wb_hit = sb.wb_valid & (sb.wb_addr != '0) & var_vec[sb.wb_addr];

    always_comb begin
        // Same-cycle writeback bypass: a result returning now is forwardable now.
        rs_pend = (sb.rs_addr != '0) & busy_mask_q[sb.rs_addr]
                  & ~(wb_hit & (sb.wb_addr == sb.rs_addr));
        rt_pend = (sb.rt_addr != '0) & busy_mask_q[sb.rt_addr]
                  & ~(wb_hit & (sb.wb_addr == sb.rt_addr));
        // WAW against an outstanding variable op on the same destination.
        waw_var = sb.issue_we & (sb.issue_addr != '0) & var_vec[sb.issue_addr]
                  & ~(wb_hit & (sb.wb_addr == sb.issue_addr));
        // Unit full, unless a writeback frees a slot in this very cycle.
        var_full = sb.issue_we & (sb.issue_lat == '0)
                   & (var_count_q == VAR_CNT_W'(MAX_VAR)) & ~wb_hit;
        stall = sb.issue_valid & ~sb.kill
                & ((sb.rs_used & rs_pend) | (sb.rt_used & rt_pend) | waw_var | var_full);
        // A flushed cycle never creates a new entry.
        accept = sb.issue_valid & ~stall & ~sb.kill & ~sb.flush
                 & sb.issue_we & (sb.issue_addr != '0);
        accept_var = accept & (sb.issue_lat == '0);
    end

    assign var_vec[0] = 1'b0;
    assign busy_d[0]  = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_reg
            logic [LAT_W-1:0] cnt_q;
            logic [LAT_W-1:0] cnt_d;
            logic             var_q;
            logic             var_d;
            logic             hit_issue;
            logic             hit_wb;

            always_comb begin
                hit_issue = accept & (sb.issue_addr == ADDR_W'(gi));
                hit_wb    = wb_hit & (sb.wb_addr == ADDR_W'(gi));
                cnt_d = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
                if (sb.flush) begin
                    cnt_d = '0;
                end
                if (hit_issue) begin
                    cnt_d = accept_var ? '0 : sb.issue_lat - 1'b1;
                end
                var_d = var_q;
                if (hit_wb) begin
                    var_d = 1'b0;
                end
                // Issue wins over a same-cycle writeback to the same register.
                if (hit_issue & accept_var) begin
                    var_d = 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q <= '0;
                    var_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    var_q <= var_d;
                end
            end

            assign var_vec[gi] = var_q;
            assign busy_d[gi]  = var_d | (cnt_d != '0);
        end
    endgenerate

    always_comb begin
        var_count_d = var_count_q;
        case ({accept_var, wb_hit})
            2'b10:   var_count_d = var_count_q + 1'b1;
            2'b01:   var_count_d = var_count_q - 1'b1;
            default: var_count_d = var_count_q;
        endcase
        // Any writeback that did not retire a variable op is a protocol error.
        wb_err_d = wb_err_q | (sb.wb_valid & ~wb_hit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_mask_q <= '0;
            var_count_q <= '0;
            wb_err_q    <= 1'b0;
        end else begin
            busy_mask_q <= busy_d;
            var_count_q <= var_count_d;
            wb_err_q    <= wb_err_d;
        end
    end

    assign sb.stall     = stall;
    assign sb.busy_mask = busy_mask_q;
    assign sb.var_count = var_count_q;
    assign sb.wb_err    = wb_err_q;

endmodule

// File: tb/tb_decode_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_decode_scoreboard
// Directed scenarios followed by randomized traffic, checked against a
// behavioural model that tracks "cycles until forwardable" per register.
// ---------------------------------------------------------------------------
module tb_decode_scoreboard;
    localparam int NUM_REGS  = 32;
    localparam int ADDR_W    = 5;
    localparam int LAT_W     = 3;
    localparam int MAX_VAR   = 4;
    localparam int VAR_CNT_W = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decode_scoreboard_if #(
        .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .LAT_W(LAT_W), .VAR_CNT_W(VAR_CNT_W)
    ) sb_if ();

    decode_scoreboard #(
        .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .LAT_W(LAT_W),
        .MAX_VAR(MAX_VAR), .VAR_CNT_W(VAR_CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb_if)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: cycles remaining until a fixed result is forwardable,
    // variable-op pending flags, outstanding count, sticky error.
    int rem   [NUM_REGS];
    bit varp  [NUM_REGS];
    int vcount;
    bit err;

    function automatic bit m_busy(int a);
        return (a != 0) && (varp[a] || rem[a] > 0);
    endfunction

    function automatic logic [NUM_REGS-1:0] m_mask();
        logic [NUM_REGS-1:0] m;
        m = '0;
        for (int r = 1; r < NUM_REGS; r++) m[r] = m_busy(r);
        return m;
    endfunction

    function automatic bit m_returning(int a);
        return sb_if.wb_valid && (int'(sb_if.wb_addr) == a) && a != 0 && varp[a];
    endfunction

    function automatic bit m_stall();
        bit s;
        int rs, rt, d;
        rs = int'(sb_if.rs_addr);
        rt = int'(sb_if.rt_addr);
        d  = int'(sb_if.issue_addr);
        if (!sb_if.issue_valid || sb_if.kill) return 1'b0;
        s = 1'b0;
        if (sb_if.rs_used && m_busy(rs) && !m_returning(rs)) s = 1'b1;
        if (sb_if.rt_used && m_busy(rt) && !m_returning(rt)) s = 1'b1;
        if (sb_if.issue_we && d != 0 && varp[d] && !m_returning(d)) s = 1'b1;
        if (sb_if.issue_we && sb_if.issue_lat == 0 && vcount == MAX_VAR
            && !m_returning(int'(sb_if.wb_addr))) s = 1'b1;
        return s;
    endfunction

    task automatic drive(input bit v, input bit we, input int addr, input int lat,
                         input int rs, input bit rsu, input int rt, input bit rtu,
                         input bit k, input bit fl, input bit wbv, input int wba);
        sb_if.issue_valid = v;
        sb_if.issue_we    = we;
        sb_if.issue_addr  = ADDR_W'(addr);
        sb_if.issue_lat   = LAT_W'(lat);
        sb_if.rs_addr     = ADDR_W'(rs);
        sb_if.rs_used     = rsu;
        sb_if.rt_addr     = ADDR_W'(rt);
        sb_if.rt_used     = rtu;
        sb_if.kill        = k;
        sb_if.flush       = fl;
        sb_if.wb_valid    = wbv;
        sb_if.wb_addr     = ADDR_W'(wba);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Advance one clock and update the model with the inputs of that cycle.
    task automatic tick();
        bit st, acc, ret;
        int d, w;
        st  = m_stall();
        d   = int'(sb_if.issue_addr);
        w   = int'(sb_if.wb_addr);
        acc = sb_if.issue_valid && !st && !sb_if.kill && !sb_if.flush
              && sb_if.issue_we && d != 0;
        ret = m_returning(w);
        @(posedge clk);
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin rem[r] = 0; varp[r] = 0; end
            vcount = 0;
            err    = 0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (sb_if.flush) rem[r] = 0;
                else if (rem[r] > 0) rem[r]--;
            end
            if (ret) begin varp[w] = 0; vcount--; end
            if (sb_if.wb_valid && !ret) err = 1;
            if (acc) begin
                if (sb_if.issue_lat == 0) begin varp[d] = 1; rem[d] = 0; vcount++; end
                else rem[d] = int'(sb_if.issue_lat) - 1;
            end
        end
        #1;
        cyc++;
        $display("cyc %0d rst=%0d v=%0d we=%0d d=%0d lat=%0d rs=%0d/%0d rt=%0d/%0d k=%0d fl=%0d wb=%0d/%0d stall=%0d acc=%0d -> busy=%h vc=%0d err=%0d",
                 cyc, rst, sb_if.issue_valid, sb_if.issue_we, d, sb_if.issue_lat,
                 sb_if.rs_addr, sb_if.rs_used, sb_if.rt_addr, sb_if.rt_used,
                 sb_if.kill, sb_if.flush, sb_if.wb_valid, w, st, acc,
                 sb_if.busy_mask, sb_if.var_count, sb_if.wb_err);
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_checks++;
        if (sb_if.busy_mask !== '0) begin
            n_fail++; $display("FAIL reset_busy got=%h exp=0", sb_if.busy_mask);
        end
        n_checks++;
        if (sb_if.var_count !== '0) begin
            n_fail++; $display("FAIL reset_var_count got=%0d exp=0", sb_if.var_count);
        end
        n_checks++;
        if (sb_if.wb_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_wb_err got=%0d exp=0", sb_if.wb_err);
        end
        drive(1, 1, 5, 2, 5, 1, 6, 1, 0, 0, 0, 0);
        n_checks++;
        if (sb_if.stall !== 1'b0) begin
            n_fail++; $display("FAIL reset_stall got=%0d exp=0", sb_if.stall);
        end
        idle();
    endtask

    task automatic test_load_use();
        drive(1, 1, 5, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (sb_if.stall !== 1'b0) begin
            n_fail++; $display("FAIL load_issue_stall got=%0d exp=0", sb_if.stall);
        end
        tick();
        n_checks++;
        if (sb_if.busy_mask[5] !== 1'b1) begin
            n_fail++; $display("FAIL load_busy_set got=%0d exp=1", sb_if.busy_mask[5]);
        end
        drive(1, 0, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (sb_if.stall !== 1'b1) begin
            n_fail++; $display("FAIL load_use_stall got=%0d exp=1", sb_if.stall);
        end
        tick();
        n_checks++;
        if (sb_if.busy_mask[5] !== 1'b0) begin
            n_fail++; $display("FAIL load_busy_clear got=%0d exp=0", sb_if.busy_mask[5]);
        end
        n_checks++;
        if (sb_if.stall !== 1'b0) begin
            n_fail++; $display("FAIL load_use_release got=%0d exp=0", sb_if.stall);
        end
        tick();
        idle();
    endtask

    task automatic test_alu_chain();
        drive(1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        n_checks++;
        if (sb_if.busy_mask[3] !== 1'b0) begin
            n_fail++; $display("FAIL alu_busy got=%0d exp=0", sb_if.busy_mask[3]);
        end
        drive(1, 1, 4, 1, 3, 1, 3, 1, 0, 0, 0, 0);
        n_checks++;
        if (sb_if.stall !== 1'b0) begin
            n_fail++; $display("FAIL alu_chain_stall got=%0d exp=0", sb_if.stall);
        end
        tick();
        idle();
    endtask

    task automatic test_variable();
        drive(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        n_checks++;
        if (sb_if.var_count !== 3'd1) begin
            n_fail++; $display("FAIL var_count_inc got=%0d exp=1", sb_if.var_count);
        end
        drive(1, 0, 0, 1, 0, 0, 7, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (sb_if.stall !== 1'b1) begin
                n_fail++; $display("FAIL var_wait_stall[%0d] got=%0d exp=1", i, sb_if.stall);
            end
            tick();
        end
        drive(1, 0, 0, 1, 0, 0, 7, 1, 0, 0, 1, 7);
        n_checks++;
        if (sb_if.stall !== 1'b0) begin
            n_fail++; $display("FAIL var_wb_bypass got=%0d exp=0", sb_if.stall);
        end
        tick();
        n_checks++;
        if (sb_if.var_count !== 3'd0 || sb_if.busy_mask[7] !== 1'b0) begin
            n_fail++; $display("FAIL var_retire got vc=%0d busy7=%0d exp vc=0 busy7=0",
                               sb_if.var_count, sb_if.busy_mask[7]);
        end
        idle();
    endtask

    task automatic test_capacity();
        for (int r = 1; r <= 4; r++) begin
            drive(1, 1, r, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            n_checks++;
            if (sb_if.stall !== 1'b0) begin
                n_fail++; $display("FAIL cap_fill_stall[%0d] got=%0d exp=0", r, sb_if.stall);
            end
            tick();
        end
        n_checks++;
        if (sb_if.var_count !== 3'd4) begin
            n_fail++; $display("FAIL cap_full_count got=%0d exp=4", sb_if.var_count);
        end
        drive(1, 1, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (sb_if.stall !== 1'b1) begin
            n_fail++; $display("FAIL cap_fifth_stall got=%0d exp=1", sb_if.stall);
        end
        tick();
        drive(1, 1, 10, 0, 0, 0, 0, 0, 0, 0, 1, 2);
        n_checks++;
        if (sb_if.stall !== 1'b0) begin
            n_fail++; $display("FAIL cap_wb_free_stall got=%0d exp=0", sb_if.stall);
        end
        tick();
        n_checks++;
        if (sb_if.var_count !== 3'd4 || sb_if.busy_mask[10] !== 1'b1 || sb_if.busy_mask[2] !== 1'b0) begin
            n_fail++; $display("FAIL cap_swap got vc=%0d b10=%0d b2=%0d exp vc=4 b10=1 b2=0",
                               sb_if.var_count, sb_if.busy_mask[10], sb_if.busy_mask[2]);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);  tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3);  tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4);  tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 10); tick();
        n_checks++;
        if (sb_if.var_count !== 3'd0 || sb_if.wb_err !== 1'b0) begin
            n_fail++; $display("FAIL cap_drain got vc=%0d err=%0d exp vc=0 err=0",
                               sb_if.var_count, sb_if.wb_err);
        end
        idle();
    endtask

    task automatic test_flush_kill();
        drive(1, 1, 9, 4, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        n_checks++;
        if (sb_if.busy_mask[9] !== 1'b0) begin
            n_fail++; $display("FAIL flush_clear got=%0d exp=0", sb_if.busy_mask[9]);
        end
        drive(1, 1, 12, 3, 0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        n_checks++;
        if (sb_if.busy_mask[12] !== 1'b0) begin
            n_fail++; $display("FAIL flush_blocks_issue got=%0d exp=0", sb_if.busy_mask[12]);
        end
        drive(1, 1, 11, 3, 0, 0, 0, 0, 1, 0, 0, 0);
        tick();
        n_checks++;
        if (sb_if.busy_mask[11] !== 1'b0) begin
            n_fail++; $display("FAIL kill_no_entry got=%0d exp=0", sb_if.busy_mask[11]);
        end
        drive(1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        n_checks++;
        if (sb_if.stall !== 1'b0) begin
            n_fail++; $display("FAIL r0_stall got=%0d exp=0", sb_if.stall);
        end
        tick();
        n_checks++;
        if (sb_if.var_count !== 3'd0 || sb_if.busy_mask !== '0) begin
            n_fail++; $display("FAIL r0_no_entry got vc=%0d busy=%h exp vc=0 busy=0",
                               sb_if.var_count, sb_if.busy_mask);
        end
        idle();
    endtask

    task automatic test_error_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6);
        tick();
        n_checks++;
        if (sb_if.wb_err !== 1'b1) begin
            n_fail++; $display("FAIL err_set got=%0d exp=1", sb_if.wb_err);
        end
        drive(1, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        n_checks++;
        if (sb_if.wb_err !== 1'b1 || sb_if.busy_mask[8] !== 1'b1) begin
            n_fail++; $display("FAIL err_sticky got err=%0d b8=%0d exp err=1 b8=1",
                               sb_if.wb_err, sb_if.busy_mask[8]);
        end
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (sb_if.busy_mask !== '0 || sb_if.var_count !== '0 || sb_if.wb_err !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset got busy=%h vc=%0d err=%0d exp 0/0/0",
                               sb_if.busy_mask, sb_if.var_count, sb_if.wb_err);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8);
        tick();
        n_checks++;
        if (sb_if.wb_err !== 1'b1) begin
            n_fail++; $display("FAIL late_wb_err got=%0d exp=1", sb_if.wb_err);
        end
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_random();
        int wba;
        bit wbv;
        int lat;
        for (int i = 0; i < 400; i++) begin
            lat = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 7);
            wbv = 1'b0;
            wba = 0;
            if ($urandom_range(0, 2) == 0) begin
                for (int t = 0; t < 8; t++) begin
                    int c;
                    c = $urandom_range(1, 7);
                    if (varp[c]) begin wbv = 1'b1; wba = c; break; end
                end
            end else if ($urandom_range(0, 40) == 0) begin
                wbv = 1'b1;
                wba = $urandom_range(0, 7);
            end
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7), lat,
                  $urandom_range(0, 7), $urandom_range(0, 1) != 0,
                  $urandom_range(0, 7), $urandom_range(0, 1) != 0,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 19) == 0,
                  wbv, wba);
            n_checks++;
            if (sb_if.stall !== m_stall()) begin
                n_fail++; $display("FAIL rand_stall[%0d] got=%0d exp=%0d", i, sb_if.stall, m_stall());
            end
            tick();
            n_checks++;
            if (sb_if.busy_mask !== m_mask()) begin
                n_fail++; $display("FAIL rand_busy[%0d] got=%h exp=%h", i, sb_if.busy_mask, m_mask());
            end
            n_checks++;
            if (int'(sb_if.var_count) != vcount || sb_if.wb_err !== err) begin
                n_fail++; $display("FAIL rand_count_err[%0d] got vc=%0d err=%0d exp vc=%0d err=%0d",
                                   i, sb_if.var_count, sb_if.wb_err, vcount, err);
            end
        end
        idle();
    endtask

    initial begin
        for (int r = 0; r < NUM_REGS; r++) begin rem[r] = 0; varp[r] = 0; end
        vcount = 0;
        err    = 0;
        idle();
        test_reset();
        test_load_use();
        test_alu_chain();
        test_variable();
        test_capacity();
        test_flush_kill();
        test_error_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
